// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: instruction field
// positions, opcode constants, state encoding and opcode classification.
package cpu_ctrl_pkg;

  // Instruction register field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_SHRA = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b10010;

  localparam logic [4:0] ALU_NONE = 5'b00000;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  // Execution flavour of an opcode; unknown codes fold into CLS_NOP
  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_REG    = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_MULDIV = 3'd3,
    CLS_LD     = 3'd4,
    CLS_ST     = 3'd5,
    CLS_HALT   = 3'd6
  } op_class_t;

  // All single-bit datapath strobes, grouped so defaults are one assignment
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic read;
    logic write;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlo_in;
    logic zhi_in;
    logic zlo_out;
    logic zhi_out;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
    logic c_out;
  } strobe_t;

  function automatic op_class_t classify_op(input logic [4:0] op);
    op_class_t cls;
    cls = CLS_NOP;
    if (op == OP_LD) begin
      cls = CLS_LD;
    end else if (op == OP_ST) begin
      cls = CLS_ST;
    end else if (op >= OP_AND && op <= OP_SHRA) begin
      cls = CLS_REG;
    end else if (op >= OP_ADDI && op <= OP_ORI) begin
      cls = CLS_IMM;
    end else if (op == OP_MUL || op == OP_DIV) begin
      cls = CLS_MULDIV;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

  // Immediate forms reuse the ALU code of their register counterpart
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    logic [4:0] sel;
    sel = OP_ADD;
    if (op == OP_ANDI) begin
      sel = OP_AND;
    end else if (op == OP_ORI) begin
      sel = OP_OR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot decoder for register file load/drive enables.
module reg_select_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  // Single bit set at position sel when enabled, otherwise all zero
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) followed by opcode-dependent
// execute steps (T3-T7). Outputs are a combinational decode of state and IR.
//
// Memory handshake: while Read or Write is high the access is outstanding;
// mem_ready high in that same cycle means the access completes on the next
// rising edge and the sequencer advances. With mem_ready low the sequencer
// holds its state and keeps the strobes asserted. mem_ready is ignored in
// every other state.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOin,
  output logic        ZHIin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        Loin,
  output logic        HIout,
  output logic        Loout,
  output logic        Cout,
  output logic [4:0]  ALUSelection,
  output logic        Run,
  output logic [3:0]  dbg_state
);

  state_t     state_q;
  state_t     state_d;
  strobe_t    strb;
  logic       rin_en;
  logic [3:0] rin_sel;
  logic       rout_en;
  logic [3:0] rout_sel;
  logic [4:0] alu_sel;
  logic       run;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  op_class_t  op_cls;
  logic       unused_ir;

  assign opcode    = IR[OPC_HI:OPC_LO];
  assign ra        = IR[RA_HI:RA_LO];
  assign rb        = IR[RB_HI:RB_LO];
  assign rc        = IR[RC_HI:RC_LO];
  assign op_cls    = classify_op(opcode);
  assign unused_ir = ^IR[RC_LO-1:0];

  // State register; clr wins over any pending memory handshake
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    strb     = '0;
    rin_en   = 1'b0;
    rin_sel  = ra;
    rout_en  = 1'b0;
    rout_sel = ra;
    alu_sel  = ALU_NONE;
    run      = 1'b1;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_T0;
      end

      ST_T0: begin
        strb.pc_out = 1'b1;
        strb.mar_in = 1'b1;
        strb.inc_pc = 1'b1;
        strb.z_in   = 1'b1;
        strb.zlo_in = 1'b1;
        state_d     = ST_T1;
      end

      // Instruction read; incremented PC is committed only on completion
      ST_T1: begin
        strb.zlo_out = 1'b1;
        strb.read    = 1'b1;
        strb.mdr_in  = 1'b1;
        if (mem_ready) begin
          strb.pc_in = 1'b1;
          state_d    = ST_T2;
        end
      end

      ST_T2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
        state_d      = ST_T3;
      end

      ST_T3: begin
        case (op_cls)
          CLS_NOP: begin
            state_d = ST_T0;
          end
          CLS_HALT: begin
            state_d = ST_HALT;
          end
          CLS_MULDIV: begin
            rout_en   = 1'b1;
            rout_sel  = ra;
            strb.y_in = 1'b1;
            state_d   = ST_T4;
          end
          default: begin
            rout_en   = 1'b1;
            rout_sel  = rb;
            strb.y_in = 1'b1;
            state_d   = ST_T4;
          end
        endcase
      end

      ST_T4: begin
        state_d = ST_T5;
        case (op_cls)
          CLS_REG: begin
            rout_en     = 1'b1;
            rout_sel    = rc;
            alu_sel     = opcode;
            strb.z_in   = 1'b1;
            strb.zlo_in = 1'b1;
          end
          CLS_IMM: begin
            strb.c_out  = 1'b1;
            alu_sel     = imm_alu_op(opcode);
            strb.z_in   = 1'b1;
            strb.zlo_in = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en     = 1'b1;
            rout_sel    = rb;
            alu_sel     = opcode;
            strb.z_in   = 1'b1;
            strb.zlo_in = 1'b1;
            strb.zhi_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            strb.c_out  = 1'b1;
            alu_sel     = OP_ADD;
            strb.z_in   = 1'b1;
            strb.zlo_in = 1'b1;
          end
          default: begin
            state_d = ST_T0;
          end
        endcase
      end

      ST_T5: begin
        case (op_cls)
          CLS_REG, CLS_IMM: begin
            strb.zlo_out = 1'b1;
            rin_en       = 1'b1;
            rin_sel      = ra;
            state_d      = ST_T0;
          end
          CLS_MULDIV: begin
            strb.zlo_out = 1'b1;
            strb.lo_in   = 1'b1;
            state_d      = ST_T6;
          end
          CLS_LD, CLS_ST: begin
            strb.zlo_out = 1'b1;
            strb.mar_in  = 1'b1;
            state_d      = ST_T6;
          end
          default: begin
            state_d = ST_T0;
          end
        endcase
      end

      ST_T6: begin
        case (op_cls)
          CLS_MULDIV: begin
            strb.zhi_out = 1'b1;
            strb.hi_in   = 1'b1;
            state_d      = ST_T0;
          end
          CLS_LD: begin
            strb.read   = 1'b1;
            strb.mdr_in = 1'b1;
            if (mem_ready) begin
              state_d = ST_T7;
            end
          end
          CLS_ST: begin
            rout_en     = 1'b1;
            rout_sel    = ra;
            strb.mdr_in = 1'b1;
            state_d     = ST_T7;
          end
          default: begin
            state_d = ST_T0;
          end
        endcase
      end

      ST_T7: begin
        case (op_cls)
          CLS_LD: begin
            strb.mdr_out = 1'b1;
            rin_en       = 1'b1;
            rin_sel      = ra;
            state_d      = ST_T0;
          end
          CLS_ST: begin
            strb.write = 1'b1;
            if (mem_ready) begin
              state_d = ST_T0;
            end
          end
          default: begin
            state_d = ST_T0;
          end
        endcase
      end

      ST_HALT: begin
        run = 1'b0;
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  reg_select_decoder u_rin_dec (
    .en     (rin_en),
    .sel    (rin_sel),
    .onehot (Rin)
  );

  reg_select_decoder u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

  assign PCout        = strb.pc_out;
  assign PCin         = strb.pc_in;
  assign IncPC        = strb.inc_pc;
  assign MARin        = strb.mar_in;
  assign MDRin        = strb.mdr_in;
  assign MDRout       = strb.mdr_out;
  assign Read         = strb.read;
  assign Write        = strb.write;
  assign IRin         = strb.ir_in;
  assign Yin          = strb.y_in;
  assign Zin          = strb.z_in;
  assign ZLOin        = strb.zlo_in;
  assign ZHIin        = strb.zhi_in;
  assign ZLOout       = strb.zlo_out;
  assign ZHIout       = strb.zhi_out;
  assign HIin         = strb.hi_in;
  assign Loin         = strb.lo_in;
  assign HIout        = strb.hi_out;
  assign Loout        = strb.lo_out;
  assign Cout         = strb.c_out;
  assign ALUSelection = alu_sel;
  assign Run          = run;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction timeline model builds the
// expected cycle-by-cycle outputs, a driver replays it against the DUT.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
  logic Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout;
  logic [4:0]  ALUSelection;
  logic        Run;
  logic [3:0]  dbg_state;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .ZLOin(ZLOin), .ZHIin(ZHIin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .Loin(Loin), .HIout(HIout), .Loout(Loout), .Cout(Cout),
    .ALUSelection(ALUSelection), .Run(Run), .dbg_state(dbg_state)
  );

  // Strobe masks, bit order matches the observed vector below
  localparam logic [19:0] M_PCOUT  = 20'h80000;
  localparam logic [19:0] M_PCIN   = 20'h40000;
  localparam logic [19:0] M_INCPC  = 20'h20000;
  localparam logic [19:0] M_MARIN  = 20'h10000;
  localparam logic [19:0] M_MDRIN  = 20'h08000;
  localparam logic [19:0] M_MDROUT = 20'h04000;
  localparam logic [19:0] M_READ   = 20'h02000;
  localparam logic [19:0] M_WRITE  = 20'h01000;
  localparam logic [19:0] M_IRIN   = 20'h00800;
  localparam logic [19:0] M_YIN    = 20'h00400;
  localparam logic [19:0] M_ZIN    = 20'h00200;
  localparam logic [19:0] M_ZLOIN  = 20'h00100;
  localparam logic [19:0] M_ZHIIN  = 20'h00080;
  localparam logic [19:0] M_ZLOOUT = 20'h00040;
  localparam logic [19:0] M_ZHIOUT = 20'h00020;
  localparam logic [19:0] M_HIIN   = 20'h00010;
  localparam logic [19:0] M_LOIN   = 20'h00008;
  localparam logic [19:0] M_COUT   = 20'h00001;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one entry per clock cycle
  logic [57:0] exp_q[$];
  logic        mr_q[$];
  logic        clr_q[$];
  logic [31:0] ir_q[$];
  string       tag_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  string cur_name;

  task automatic push(input logic c, input logic mr, input logic [31:0] ir,
                      input logic [15:0] rin, input logic [15:0] rout,
                      input logic [19:0] strb, input logic [4:0] alu,
                      input logic run, input string step);
    exp_q.push_back({rin, rout, strb, alu, run});
    mr_q.push_back(mr);
    clr_q.push_back(c);
    ir_q.push_back(ir);
    tag_q.push_back({cur_name, "_", step});
  endtask

  task automatic push_reset(input logic [31:0] ir);
    push(1'b0, 1'($urandom_range(0, 1)), ir, 16'h0, 16'h0, 20'h0, 5'd0, 1'b1, "RESET");
  endtask

  // Expected timeline of one instruction. fw/mw: memory wait cycles for the
  // fetch and the data access. abort_at >= 0 asserts clr in that cycle.
  task automatic model_instr(input logic [31:0] ir, input int fw, input int mw,
                             input int abort_at, input string name);
    int s;
    logic [4:0] op;
    logic [15:0] oh_a, oh_b, oh_c;
    logic [4:0] imm_sel;
    cur_name = name;
    s    = exp_q.size();
    op   = ir[31:27];
    oh_a = 16'h1 << ir[26:23];
    oh_b = 16'h1 << ir[22:19];
    oh_c = 16'h1 << ir[18:15];
    push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_ZLOIN, 0, 1, "T0");
    for (int w = 0; w < fw; w++)
      push(1'b0, 1'b0, ir, 0, 0, M_ZLOOUT | M_READ | M_MDRIN, 0, 1, "T1wait");
    push(1'b0, 1'b1, ir, 0, 0, M_ZLOOUT | M_READ | M_MDRIN | M_PCIN, 0, 1, "T1");
    push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_MDROUT | M_IRIN, 0, 1, "T2");
    if (op >= 5'd3 && op <= 5'd11) begin
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_b, M_YIN, 0, 1, "T3");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_c, M_ZIN | M_ZLOIN, op, 1, "T4");
      push(1'b0, 1'($urandom_range(0, 1)), ir, oh_a, 0, M_ZLOOUT, 0, 1, "T5");
    end else if (op >= 5'd12 && op <= 5'd14) begin
      imm_sel = (op == 5'd12) ? 5'd5 : (op == 5'd13) ? 5'd3 : 5'd4;
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_b, M_YIN, 0, 1, "T3");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_COUT | M_ZIN | M_ZLOIN, imm_sel, 1, "T4");
      push(1'b0, 1'($urandom_range(0, 1)), ir, oh_a, 0, M_ZLOOUT, 0, 1, "T5");
    end else if (op == 5'd15 || op == 5'd16) begin
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_a, M_YIN, 0, 1, "T3");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_b, M_ZIN | M_ZLOIN | M_ZHIIN, op, 1, "T4");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_ZLOOUT | M_LOIN, 0, 1, "T5");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_ZHIOUT | M_HIIN, 0, 1, "T6");
    end else if (op == 5'd0 || op == 5'd1) begin
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_b, M_YIN, 0, 1, "T3");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_COUT | M_ZIN | M_ZLOIN, 5'd5, 1, "T4");
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, M_ZLOOUT | M_MARIN, 0, 1, "T5");
      if (op == 5'd0) begin
        for (int w = 0; w < mw; w++)
          push(1'b0, 1'b0, ir, 0, 0, M_READ | M_MDRIN, 0, 1, "T6wait");
        push(1'b0, 1'b1, ir, 0, 0, M_READ | M_MDRIN, 0, 1, "T6");
        push(1'b0, 1'($urandom_range(0, 1)), ir, oh_a, 0, M_MDROUT, 0, 1, "T7");
      end else begin
        push(1'b0, 1'($urandom_range(0, 1)), ir, 0, oh_a, M_MDRIN, 0, 1, "T6");
        for (int w = 0; w < mw; w++)
          push(1'b0, 1'b0, ir, 0, 0, M_WRITE, 0, 1, "T7wait");
        push(1'b0, 1'b1, ir, 0, 0, M_WRITE, 0, 1, "T7");
      end
    end else if (op == 5'd18) begin
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, 20'h0, 0, 1, "T3");
      for (int h = 0; h < 20; h++)
        push(h == 19, 1'(h % 2), ir, 0, 0, 20'h0, 0, 0, "HALT");
      push_reset(ir);
    end else begin
      push(1'b0, 1'($urandom_range(0, 1)), ir, 0, 0, 20'h0, 0, 1, "T3");
    end
    if (abort_at >= 0) begin
      while (exp_q.size() > s + abort_at + 1) begin
        void'(exp_q.pop_back());
        void'(mr_q.pop_back());
        void'(clr_q.pop_back());
        void'(ir_q.pop_back());
        void'(tag_q.pop_back());
      end
      clr_q[s + abort_at] = 1'b1;
      push_reset(ir);
    end
  endtask

  // Driver and checker: inputs just after the rising edge, sample on falling
  task automatic run_queue();
    logic [57:0] e, obs;
    string t;
    while (exp_q.size() > 0) begin
      clr       = clr_q.pop_front();
      mem_ready = mr_q.pop_front();
      IR        = ir_q.pop_front();
      e         = exp_q.pop_front();
      t         = tag_q.pop_front();
      @(negedge clk);
      obs = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
             IRin, Yin, Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, HIout,
             Loout, Cout, ALUSelection, Run};
      n_assert++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
      n_assert++;
      assert (!(Read && Write) && $onehot0(Rout) &&
              ($countones({PCout, MDRout, ZLOout, ZHIout, HIout, Loout, Cout, |Rout}) <= 1))
      else begin
        n_fail++;
        $error("FAIL %s_bus_rules: observed rd=%b wr=%b rout=%h expected exclusive", t, Read, Write, Rout);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rir;
    logic [4:0]  rop;
    clr       = 1'b1;
    IR        = 32'h0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;

    cur_name = "init";
    push_reset(32'h0);
    model_instr(32'h28918000, 0, 0, -1, "add_r1_r2_r3");
    model_instr(32'h88000000, 3, 0, -1, "fetch_wait3");
    model_instr(32'h01080065, 0, 2, -1, "ld_r2");
    model_instr({5'b00001, 27'($urandom)}, 1, 3, -1, "st");
    model_instr(32'h79A00000, 0, 0, -1, "mul_r3_r4");
    model_instr({5'b10000, 27'($urandom)}, 0, 0, -1, "div");
    model_instr({5'b01100, 27'($urandom)}, 0, 0, -1, "addi");
    model_instr({5'b01101, 27'($urandom)}, 2, 0, -1, "andi");
    model_instr({5'b01110, 27'($urandom)}, 0, 0, -1, "ori");
    model_instr({5'b11111, 27'($urandom)}, 0, 0, -1, "unknown");
    model_instr(32'h28918000, 0, 0, 4, "clr_in_T4");
    model_instr(32'h28918000, 2, 0, 1, "clr_in_T1wait");
    model_instr(32'h01080065, 0, 3, 7, "clr_in_ld_T6wait");
    model_instr({5'b00001, 27'($urandom)}, 0, 2, 8, "clr_in_st_T7wait");
    for (int i = 0; i < 30; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd18) rop = 5'd17;
      rir = {rop, 27'($urandom)};
      model_instr(rir, $urandom_range(0, 3), $urandom_range(0, 3), -1, "random");
    end
    model_instr(32'h90000000, 0, 0, -1, "halt");
    model_instr(32'h28918000, 0, 0, -1, "after_halt");
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (sole clock domain).
REQ-002 SHALL have ports: clr  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: IR  in  32  datapath instruction register; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-004 SHALL have ports: mem_ready  in  1  memory handshake; high = current Read/Write completes this cycle.
REQ-005 SHALL have ports: Rin, Rout  out  16 each  one-hot register load/drive enables for R0..R15.
REQ-006 SHALL have ports: PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout  out  1 each  datapath strobes.
REQ-007 SHALL have ports: ALUSelection  out  5  ALU operation code.
REQ-008 SHALL have ports: Run  out  1  high unless halted.

Function
REQ-009 Outputs SHALL be combinational decode of the current state and IR; state SHALL be registered.
REQ-010 States: RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
REQ-011 Any strobe not listed for a state SHALL be 0; Rin/Rout SHALL be 0 unless listed; ALUSelection SHALL be 00000 unless listed.
REQ-012 RESET: all outputs 0, Run=1; next state T0.
REQ-013 T0: PCout, MARin, IncPC, Zin, ZLOin; next T1.
REQ-014 T1: ZLOout, Read, MDRin held; PCin only in the cycle mem_ready=1; stay in T1 while mem_ready=0; else next T2.
REQ-015 T2: MDRout, IRin; next T3.
REQ-016 Opcodes: ld 00000, st 00001, and 00011, or 00100, add 00101, sub 00110, shr 00111, shl 01000, ror 01001, rol 01010, shra 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, nop 10001, halt 10010; any other code SHALL execute as nop.
REQ-017 Register ops (00011-01011): T3 Rout[Rb], Yin; T4 Rout[Rc], ALUSelection=opcode, Zin, ZLOin; T5 ZLOout, Rin[Ra]; then T0.
REQ-018 Immediate ops: T3 Rout[Rb], Yin; T4 Cout, Zin, ZLOin, ALUSelection=00101/00011/00100 for addi/andi/ori; T5 ZLOout, Rin[Ra]; then T0.
REQ-019 mul/div: T3 Rout[Ra], Yin; T4 Rout[Rb], ALUSelection=opcode, Zin, ZLOin, ZHIin; T5 ZLOout, Loin; T6 ZHIout, HIin; then T0.
REQ-020 ld/st address: T3 Rout[Rb], Yin; T4 Cout, ALUSelection=00101, Zin, ZLOin; T5 ZLOout, MARin.
REQ-021 ld: T6 Read, MDRin, stay while mem_ready=0; T7 MDRout, Rin[Ra]; then T0.
REQ-022 st: T6 Rout[Ra], MDRin; T7 Write, stay while mem_ready=0; then T0.
REQ-023 nop/unknown: T3 no strobes; then T0.
REQ-024 halt: T3 moves to HALT; HALT: all outputs 0, Run=0; held until clr regardless of mem_ready.
REQ-025 Read and Write SHALL never be high in the same cycle; at most one Rout bit and one bus driver SHALL be active per cycle.

Reset
REQ-026 clr=1 at a rising edge SHALL force state RESET at that edge from any state, including mid-wait in T1/T6/T7 and HALT; clr has priority over mem_ready.
REQ-027 While in RESET all outputs SHALL be 0; Run=1.

Structure
REQ-028 Opcode constants, IR field positions and state encodings SHALL live in shared package cpu_ctrl_pkg.
REQ-029 4-to-16 one-hot decode SHALL be sub-module reg_select_decoder, instantiated for Rin and Rout.

Verification
REQ-030 clr, IR=0x28918000 (add R1,R2,R3), mem_ready=1: T3 Rout=0x0004,Yin; T4 Rout=0x0008,ALUSelection=00101,Zin; T5 ZLOout,Rin=0x0002; T0 six cycles after first T0.
REQ-031 Fetch with mem_ready low 3 cycles: Read/MDRin high 4 cycles, PCin high only in 4th, then T2.
REQ-032 IR=0x01080065 (ld R2,0x65(R1)): T4 Cout,ALUSelection=00101; T5 ZLOout,MARin; T6 Read until mem_ready; T7 MDRout,Rin=0x0004.
REQ-033 IR=0x79A00000 (mul R3,R4): T3 Rout=0x0008; T4 Rout=0x0010; T5 ZLOout,Loin; T6 ZHIout,HIin.
REQ-034 clr asserted during T4 of add: next cycle all outputs 0, Rin never asserted, then T0.
REQ-035 IR=0x90000000 (halt): Run=0, no strobes for 20 cycles with mem_ready toggling; clr returns RESET then T0 with Run=1.
